// File: rtl/node_integrator.sv
// node_integrator: explicit-Euler integrator for one body of NUM_NODES mass nodes.
// A frame starts with input_valid, which latches positions and velocities.
// Per-node force pairs are then collected from the spring block.
// When frame_done_in arrives, one node (both axes) is integrated per cycle.
// The finished frame is published with a one-cycle output_valid pulse.
//
// Ports:
//   clk_in, rst_in        clock (rising edge), asynchronous active-high reset
//   input_valid           start-of-frame strobe; ignored while busy
//   nodes_in              [axis][node] signed positions  (axis 0 = x, 1 = y)
//   velocities_in         [axis][node] signed velocities
//   force_x_in/_y_in      signed force pair; the nth force_in_valid of a frame is node n
//   force_in_valid        force pair strobe
//   frame_done_in         spring block finished the frame
//   nodes_out             integrated positions, updated only when output_valid rises
//   velocities_out        integrated velocities, updated with nodes_out
//   busy                  high whenever the FSM is not idle
//   output_valid          one-cycle pulse while new results are presented
//   frame_error           sticky until next accepted input_valid; wrong force count
module node_integrator #(
  parameter int unsigned NUM_NODES     = 3,
  parameter int unsigned POSITION_SIZE = 8,
  parameter int unsigned VELOCITY_SIZE = 8,
  parameter int unsigned FORCE_SIZE    = 7,
  parameter int unsigned MASS_SHIFT    = 0,
  parameter int unsigned DT_SHIFT      = 0
) (
  input  logic                                          clk_in,
  input  logic                                          rst_in,
  input  logic                                          input_valid,
  input  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]  nodes_in,
  input  logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]  velocities_in,
  input  logic [FORCE_SIZE-1:0]                         force_x_in,
  input  logic [FORCE_SIZE-1:0]                         force_y_in,
  input  logic                                          force_in_valid,
  input  logic                                          frame_done_in,
  output logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]  nodes_out,
  output logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]  velocities_out,
  output logic                                          busy,
  output logic                                          output_valid,
  output logic                                          frame_error
);

  // Index counts 0..NUM_NODES inclusive so an overflowing pulse can be detected.
  localparam int unsigned IW = $clog2(NUM_NODES + 1);
  // Intermediate sum widths: widest operand plus one guard bit.
  localparam int unsigned VW = ((VELOCITY_SIZE > FORCE_SIZE) ? VELOCITY_SIZE : FORCE_SIZE) + 1;
  localparam int unsigned PW = ((POSITION_SIZE > VELOCITY_SIZE) ? POSITION_SIZE : VELOCITY_SIZE) + 1;

  localparam logic signed [VW-1:0] V_MAX = VW'((2 ** (VELOCITY_SIZE - 1)) - 1);
  localparam logic signed [VW-1:0] V_MIN = ~V_MAX;
  localparam logic signed [PW-1:0] P_MAX = PW'((2 ** (POSITION_SIZE - 1)) - 1);
  localparam logic signed [PW-1:0] P_MIN = ~P_MAX;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] COLLECT   = 2'd1;
  localparam logic [1:0] INTEGRATE = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  logic [1:0]                                   state_q, state_d;
  logic [IW-1:0]                                idx_q, idx_d;
  logic [IW-1:0]                                node_q, node_d;
  logic [1:0][NUM_NODES-1:0][FORCE_SIZE-1:0]    force_q, force_d;
  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] pos_q, pos_d;
  logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] vel_q, vel_d;
  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] pos_out_q, pos_out_d;
  logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] vel_out_q, vel_out_d;
  logic                                         busy_q, busy_d;
  logic                                         valid_q, valid_d;
  logic                                         err_q, err_d;

  logic [1:0][VELOCITY_SIZE-1:0]                vnext;
  logic [1:0][POSITION_SIZE-1:0]                pnext;

  // v' = sat_V(v + (F >>> MASS_SHIFT))
  function automatic logic [VELOCITY_SIZE-1:0] next_vel(
    input logic [VELOCITY_SIZE-1:0] v,
    input logic [FORCE_SIZE-1:0]    f
  );
    logic signed [FORCE_SIZE-1:0] fs;
    logic signed [VW-1:0]         sum;
    fs  = $signed(f) >>> MASS_SHIFT;
    sum = VW'($signed(v)) + VW'(fs);
    if (sum > V_MAX)      next_vel = {1'b0, {(VELOCITY_SIZE-1){1'b1}}};
    else if (sum < V_MIN) next_vel = {1'b1, {(VELOCITY_SIZE-1){1'b0}}};
    else                  next_vel = sum[VELOCITY_SIZE-1:0];
  endfunction

  // p' = sat_P(p + (v' >>> DT_SHIFT))
  function automatic logic [POSITION_SIZE-1:0] next_pos(
    input logic [POSITION_SIZE-1:0] p,
    input logic [VELOCITY_SIZE-1:0] v
  );
    logic signed [VELOCITY_SIZE-1:0] vs;
    logic signed [PW-1:0]            sum;
    vs  = $signed(v) >>> DT_SHIFT;
    sum = PW'($signed(p)) + PW'(vs);
    if (sum > P_MAX)      next_pos = {1'b0, {(POSITION_SIZE-1){1'b1}}};
    else if (sum < P_MIN) next_pos = {1'b1, {(POSITION_SIZE-1){1'b0}}};
    else                  next_pos = sum[POSITION_SIZE-1:0];
  endfunction

  // Integration datapath for the node currently addressed by node_q.
  always_comb begin
    vnext = '0;
    pnext = '0;
    for (int a = 0; a < 2; a++) begin
      vnext[a] = next_vel(vel_q[a][node_q], force_q[a][node_q]);
      pnext[a] = next_pos(pos_q[a][node_q], vnext[a]);
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    node_d    = node_q;
    force_d   = force_q;
    pos_d     = pos_q;
    vel_d     = vel_q;
    pos_out_d = pos_out_q;
    vel_out_d = vel_out_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (input_valid) begin
          pos_d   = nodes_in;
          vel_d   = velocities_in;
          force_d = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (force_in_valid) begin
          if (idx_q < IW'(NUM_NODES)) begin
            force_d[0][idx_q] = force_x_in;
            force_d[1][idx_q] = force_y_in;
            idx_d             = idx_q + IW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        // Uses idx_d so a same-cycle force pulse counts before the check.
        if (frame_done_in) begin
          if (idx_d < IW'(NUM_NODES)) err_d = 1'b1;
          node_d  = '0;
          state_d = INTEGRATE;
        end
      end
      INTEGRATE: begin
        for (int a = 0; a < 2; a++) begin
          vel_d[a][node_q] = vnext[a];
          pos_d[a][node_q] = pnext[a];
        end
        if (node_q == IW'(NUM_NODES - 1)) begin
          pos_out_d = pos_d;
          vel_out_d = vel_d;
          state_d   = DONE;
        end else begin
          node_d = node_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      node_q    <= '0;
      force_q   <= '0;
      pos_q     <= '0;
      vel_q     <= '0;
      pos_out_q <= '0;
      vel_out_q <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      node_q    <= node_d;
      force_q   <= force_d;
      pos_q     <= pos_d;
      vel_q     <= vel_d;
      pos_out_q <= pos_out_d;
      vel_out_q <= vel_out_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign nodes_out      = pos_out_q;
  assign velocities_out = vel_out_q;
  assign busy           = busy_q;
  assign output_valid   = valid_q;
  assign frame_error    = err_q;

endmodule

// File: tb/tb_node_integrator.sv
// tb_node_integrator: directed self-checking bench for node_integrator.
// dut0 uses default parameters; dut1 shares all inputs but uses
// MASS_SHIFT=1, DT_SHIFT=1 to exercise the arithmetic shifts.
module tb_node_integrator;

  localparam int N = 3;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic input_valid = 1'b0;
  logic force_in_valid = 1'b0;
  logic frame_done_in = 1'b0;
  logic [1:0][N-1:0][7:0] nodes_in = '0;
  logic [1:0][N-1:0][7:0] velocities_in = '0;
  logic [6:0] force_x_in = '0;
  logic [6:0] force_y_in = '0;

  logic [1:0][N-1:0][7:0] nodes_out, velocities_out;
  logic [1:0][N-1:0][7:0] nodes_out1, velocities_out1;
  logic busy, output_valid, frame_error;
  logic busy1, output_valid1, frame_error1;

  int errors = 0;
  int checks = 0;
  int lat;
  int pulses;

  always #5 clk_in = ~clk_in;

  node_integrator dut0 (
    .clk_in(clk_in), .rst_in(rst_in), .input_valid(input_valid),
    .nodes_in(nodes_in), .velocities_in(velocities_in),
    .force_x_in(force_x_in), .force_y_in(force_y_in),
    .force_in_valid(force_in_valid), .frame_done_in(frame_done_in),
    .nodes_out(nodes_out), .velocities_out(velocities_out),
    .busy(busy), .output_valid(output_valid), .frame_error(frame_error)
  );

  node_integrator #(.MASS_SHIFT(1), .DT_SHIFT(1)) dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .input_valid(input_valid),
    .nodes_in(nodes_in), .velocities_in(velocities_in),
    .force_x_in(force_x_in), .force_y_in(force_y_in),
    .force_in_valid(force_in_valid), .frame_done_in(frame_done_in),
    .nodes_out(nodes_out1), .velocities_out(velocities_out1),
    .busy(busy1), .output_valid(output_valid1), .frame_error(frame_error1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_node(input int n, input int px, input int py, input int vx, input int vy);
    nodes_in[0][n]      = 8'(px);
    nodes_in[1][n]      = 8'(py);
    velocities_in[0][n] = 8'(vx);
    velocities_in[1][n] = 8'(vy);
  endtask

  task automatic set_nominal();
    set_node(0, 3, 4, 1, 2);
    set_node(1, 6, 8, -2, -3);
    set_node(2, 12, -2, 5, 8);
  endtask

  task automatic pulse_start();
    input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
  endtask

  task automatic send_force(input int fx, input int fy);
    force_x_in     = 7'(fx);
    force_y_in     = 7'(fy);
    force_in_valid = 1'b1;
    tick();
    force_in_valid = 1'b0;
  endtask

  // Pulses frame_done_in and returns cycles until output_valid (bounded).
  task automatic done_and_wait(output int cycles);
    frame_done_in = 1'b1;
    tick();
    frame_done_in = 1'b0;
    cycles = 1;
    while (!output_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic check_node(input string tag, input int n,
                            input int px, input int py, input int vx, input int vy);
    check({tag, ".px"}, int'($signed(nodes_out[0][n])), px);
    check({tag, ".py"}, int'($signed(nodes_out[1][n])), py);
    check({tag, ".vx"}, int'($signed(velocities_out[0][n])), vx);
    check({tag, ".vy"}, int'($signed(velocities_out[1][n])), vy);
  endtask

  task automatic check_nominal(input string tag);
    check_node({tag, ".n0"}, 0, 6, 5, 3, 1);
    check_node({tag, ".n1"}, 1, 4, 5, -2, -3);
    check_node({tag, ".n2"}, 2, 12, -2, 0, 0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst.nodes", int'(nodes_out != '0), 0);
    check("rst.vels", int'(velocities_out != '0), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.valid", int'(output_valid), 0);
    check("rst.err", int'(frame_error), 0);
    rst_in = 1'b0;
    tick();

    // Shift frame: node0 v=3, F=-3, p=10; other nodes zero
    set_node(0, 10, 10, 3, 3);
    set_node(1, 0, 0, 0, 0);
    set_node(2, 0, 0, 0, 0);
    pulse_start();
    check("shift.busy", int'(busy), 1);
    send_force(-3, -3);
    send_force(0, 0);
    send_force(0, 0);
    done_and_wait(lat);
    check("shift.latency", lat, 4);
    check("shift.valid1", int'(output_valid1), 1);
    check_node("shift.dut0", 0, 10, 10, 0, 0);
    check("shift.dut1.vx", int'($signed(velocities_out1[0][0])), 1);
    check("shift.dut1.vy", int'($signed(velocities_out1[1][0])), 1);
    check("shift.dut1.px", int'($signed(nodes_out1[0][0])), 10);
    check("shift.dut1.py", int'($signed(nodes_out1[1][0])), 10);
    check("shift.err", int'(frame_error), 0);
    tick();
    check("shift.valid_pulse", int'(output_valid), 0);
    check("shift.idle_busy", int'(busy), 0);

    // Nominal frame
    set_nominal();
    pulse_start();
    send_force(2, -1);
    send_force(0, 0);
    send_force(-5, -8);
    done_and_wait(lat);
    check("nom.latency", lat, 4);
    check_nominal("nom");
    check("nom.err", int'(frame_error), 0);
    tick();

    // Saturation on both axes
    set_node(0, 120, -120, 120, -120);
    set_node(1, 0, 0, 0, 0);
    set_node(2, 0, 0, 0, 0);
    pulse_start();
    send_force(20, -20);
    send_force(0, 0);
    send_force(0, 0);
    done_and_wait(lat);
    check("sat.latency", lat, 4);
    check_node("sat", 0, 127, -128, 127, -128);
    tick();

    // Short frame: node2 integrates with zero force
    set_nominal();
    pulse_start();
    send_force(2, -1);
    send_force(0, 0);
    done_and_wait(lat);
    check("short.latency", lat, 4);
    check_node("short.n0", 0, 6, 5, 3, 1);
    check_node("short.n2", 2, 17, 6, 5, 8);
    check("short.err", int'(frame_error), 1);
    tick();
    check("short.err_sticky", int'(frame_error), 1);

    // Extra 4th pulse dropped; error cleared by the new input_valid first
    set_nominal();
    pulse_start();
    check("extra.err_cleared", int'(frame_error), 0);
    send_force(2, -1);
    send_force(0, 0);
    send_force(-5, -8);
    send_force(30, 30);
    done_and_wait(lat);
    check("extra.latency", lat, 4);
    check_nominal("extra");
    check("extra.err", int'(frame_error), 1);
    tick();

    // Reset during INTEGRATE discards the frame
    set_node(0, 120, -120, 120, -120);
    pulse_start();
    send_force(20, -20);
    send_force(1, 1);
    send_force(1, 1);
    frame_done_in = 1'b1;
    tick();
    frame_done_in = 1'b0;
    tick();
    rst_in = 1'b1;
    #1;
    check("midrst.nodes", int'(nodes_out != '0), 0);
    check("midrst.vels", int'(velocities_out != '0), 0);
    check("midrst.busy", int'(busy), 0);
    check("midrst.err", int'(frame_error), 0);
    tick();
    rst_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (output_valid) pulses++;
      tick();
    end
    check("midrst.no_valid", pulses, 0);
    check("midrst.still_zero", int'(nodes_out != '0), 0);

    // Frame after reset; second input_valid during COLLECT is ignored
    set_nominal();
    pulse_start();
    set_node(0, 50, 50, 40, 40);
    pulse_start();
    send_force(2, -1);
    send_force(0, 0);
    send_force(-5, -8);
    done_and_wait(lat);
    check("post.latency", lat, 4);
    check_nominal("post");
    check("post.err", int'(frame_error), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/node_integrator.md
NODE_INTEGRATOR -- requirements
Module: node_integrator

Interface
REQ-001 Parameters (name, default, meaning): NUM_NODES, 3, mass nodes per body; POSITION_SIZE, 8, signed position width; VELOCITY_SIZE, 8, signed velocity width; FORCE_SIZE, 7, signed force width; MASS_SHIFT, 0, arithmetic right shift applied to force (1/m); DT_SHIFT, 0, arithmetic right shift applied to velocity (dt).
REQ-002 Ports (name, direction, width, meaning):
- clk_in  in  1  single clock; all state on rising edge.
- rst_in  in  1  reset, asynchronous, active-high.
- input_valid  in  1  one-cycle start-of-frame; latches nodes_in/velocities_in.
- nodes_in  in  [1:0][NUM_NODES] x POSITION_SIZE  node positions, [0]=x, [1]=y.
- velocities_in  in  [1:0][NUM_NODES] x VELOCITY_SIZE  node velocities.
- force_x_in, force_y_in  in  FORCE_SIZE each  per-node force from the spring block.
- force_in_valid  in  1  force pair valid; nth pulse of a frame belongs to node n.
- frame_done_in  in  1  spring block finished the frame (its output_valid).
- nodes_out  out  [1:0][NUM_NODES] x POSITION_SIZE  integrated positions.
- velocities_out  out  [1:0][NUM_NODES] x VELOCITY_SIZE  integrated velocities.
- busy  out  1  high in any state except IDLE.
- output_valid  out  1  one-cycle pulse; nodes_out/velocities_out hold new frame.
- frame_error  out  1  sticky until next input_valid; force count != NUM_NODES.

Function
REQ-003 FSM states IDLE, COLLECT, INTEGRATE, DONE; IDLE->COLLECT on input_valid; COLLECT->INTEGRATE on frame_done_in; INTEGRATE->DONE after last node; DONE->IDLE unconditionally next cycle.
REQ-004 On input_valid in IDLE: latch inputs into working registers, clear force accumulators and force index to 0, clear frame_error.
REQ-005 input_valid while busy shall be ignored; no state or register change.
REQ-006 COLLECT: each force_in_valid stores (force_x_in, force_y_in) into node slot = index, index increments; a pulse with index == NUM_NODES shall be dropped and set frame_error.
REQ-007 frame_done_in with index < NUM_NODES: unfilled slots use force 0, frame_error set; force_in_valid and frame_done_in in same cycle: force stored first, then transition.
REQ-008 force_in_valid/frame_done_in outside COLLECT shall be ignored.
REQ-009 INTEGRATE processes node i in cycle i (i = 0..NUM_NODES-1), both axes in parallel: v' = sat_V(v + (F >>> MASS_SHIFT)); p' = sat_P(p + (v' >>> DT_SHIFT)).
REQ-010 Arithmetic: sign-extend to max width + 1 before add; sat_V clamps to [-2^(VELOCITY_SIZE-1), 2^(VELOCITY_SIZE-1)-1], sat_P likewise for POSITION_SIZE; shifts are arithmetic (round toward -inf).
REQ-011 nodes_out/velocities_out update only at DONE entry (all nodes at once), hold otherwise; output_valid high exactly during DONE.
REQ-012 Latency: output_valid asserts NUM_NODES+1 cycles after the cycle frame_done_in is sampled.

Reset
REQ-013 rst_in asserted at any time (incl. mid-COLLECT/INTEGRATE): state IDLE, index 0, accumulators 0, nodes_out 0, velocities_out 0, busy 0, output_valid 0, frame_error 0; partial frame discarded, no output_valid pulse.
REQ-014 First input_valid after rst_in deasserts is accepted normally.

Verification
REQ-015 Nominal (NUM_NODES=3, shifts 0): p=(3,4),(6,8),(12,-2); v=(1,2),(-2,-3),(5,8); forces (2,-1),(0,0),(-5,-8); frame_done -> v_out=(3,1),(-2,-3),(0,0), p_out=(6,5),(4,5),(12,-2), output_valid 4 cycles after frame_done, frame_error 0.
REQ-016 Saturation: p=(120,-120), v=(120,-120), F=(20,-20) -> v_out=(127,-128), p_out=(127,-128).
REQ-017 Short frame: only 2 force pulses then frame_done -> node2 integrates with F=0 (v unchanged, p+=v), frame_error 1; extra 4th pulse in a full frame dropped, frame_error 1, outputs from first 3 forces.
REQ-018 Shifts: MASS_SHIFT=1, DT_SHIFT=1, v=3, F=-3 -> v'=3+(-2)=1, p' = p+0.
REQ-019 Reset mid-INTEGRATE (cycle 1) -> all outputs 0 next edge, no output_valid; new input_valid then completes with correct values; input_valid during COLLECT ignored (latched positions unchanged).
